lsu_mem_master: RTL and testbench
=================================

Name: lsu_mem_master

Overview:
- Initiator-side load/store unit that drives the word-addressed memory port (ren/wen/addr/wstrb/wdata -> rdata/wfinish) on behalf of the core.
- Accepts one byte/half/word load or store per transaction over a valid/ready handshake.
- Generates the aligned word address, byte strobes and replicated write data, issues a single-cycle memory strobe, and captures the registered memory result.
- Returns extracted, sign- or zero-extended load data or store status to the core. Sits between the execute stage and the memory model.

Parameters:
- MISALIGN_TRAP, 1: 1 = misaligned request completes with resp_err=1 and no memory access; 0 = low address bits ignored per size (forced alignment), access proceeds.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- req_valid  in  1  core request valid
- req_ready  out  1  unit can accept a request
- req_wen  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  response valid
- resp_ready  in  1  core accepts response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned, illegal size, or write failure
- mem_ren  out  1  memory read strobe, one-cycle pulse
- mem_wen  out  1  memory write strobe, one-cycle pulse
- mem_addr  out  32  {addr[31:2],2'b00}
- mem_wstrb  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  registered read data, valid the cycle after mem_ren
- mem_wfinish  in  1  registered write status, valid the cycle after mem_wen

Behaviour:
- Reset values: state IDLE; req_ready=1 (combinational from IDLE); resp_valid=0, resp_err=0, resp_rdata=0; mem_ren=0, mem_wen=0; mem_addr, mem_wstrb and mem_wdata = 0.
- States:
  - IDLE -> ISSUE on req_valid&&req_ready. All req_* fields are latched into internal registers.
  - IDLE -> RESP directly, with err=1 and no memory strobe, when req_size==3, or when MISALIGN_TRAP=1 and the request is misaligned (half with addr[0]=1; word with addr[1:0]!=0).
  - ISSUE: exactly one cycle; mem_ren (load) or mem_wen (store) = 1; mem_addr, mem_wstrb and mem_wdata driven from the latched request. -> WAIT.
  - WAIT: load captures mem_rdata; store captures mem_wfinish, with err = !mem_wfinish. -> RESP.
  - RESP: resp_valid=1; resp_rdata and resp_err held stable until resp_ready. On resp_valid&&resp_ready -> IDLE.
- req_ready is 1 only in IDLE, so a new request is accepted no earlier than the cycle after the response handshake.
- Latency: accept at cycle T, ISSUE at T+1, WAIT at T+2, resp_valid at T+3. Error path: resp_valid at T+1.
- Strobes: mem_ren and mem_wen are never both 1. They are 0 outside ISSUE, so each transaction produces exactly one pulse.
- Store lane rules, with off = addr[1:0]:
  - Byte: wstrb = 4'b0001<<off; wdata = {4{wdata[7:0]}}.
  - Half: wstrb = 4'b0011<<{off[1],1'b0}; wdata = {2{wdata[15:0]}}.
  - Word: wstrb = 4'b1111; wdata unchanged.
- Load extract:
  - Byte: mem_rdata[8*off +: 8].
  - Half: mem_rdata[16*off[1] +: 16].
  - Word: mem_rdata, full word.
  - Byte and half results are sign-extended (req_unsigned=0) or zero-extended (req_unsigned=1).
- Forced alignment (MISALIGN_TRAP=0): half uses off[1] only; word ignores off.
- mem_wfinish is sampled only in WAIT after a store. Its stale value at other times is ignored.
- resp_rdata is 0 for stores and all error responses.
- Reset mid-operation: on any cycle with reset=1, state returns to IDLE and all outputs take their reset values at that edge. No strobe is issued and no response is produced for the pending transaction.
- Back-pressure: resp_ready held low keeps RESP and its data indefinitely. No further memory strobes are issued meanwhile.

Test Plan:
- Load byte signed: memory word at 0x80000000 = 0x12F45678, request lb at 0x80000002 -> mem_addr=0x80000000, one mem_ren pulse at T+1, resp_rdata=0xFFFFFFF4 at T+3; same request with req_unsigned=1 -> 0x000000F4.
- Store half: sh at 0x80000006, wdata 0xDEADBEEF -> mem_addr=0x80000004, mem_wstrb=4'b1100, mem_wdata=0xBEEFBEEF, mem_wen pulse for exactly 1 cycle, mem_wfinish=1 -> resp_err=0.
- Misaligned word load at 0x80000001 with MISALIGN_TRAP=1 -> no mem_ren, resp_valid at T+1, resp_err=1, resp_rdata=0. Same request with MISALIGN_TRAP=0 -> mem_addr=0x80000000, full word returned.
- Write failure: sw with mem_wfinish driven 0 in WAIT -> resp_err=1. Illegal req_size=3 -> resp_err=1, no strobes.
- Back-pressure and throughput: resp_ready=0 for 5 cycles -> resp_valid and resp_rdata stable, req_ready=0, no strobes. Release -> req_ready=1 the next cycle; back-to-back requests complete every 4 cycles.
- Reset at ISSUE cycle of a load -> mem_ren=0 after the edge, no resp_valid, req_ready=1. The next request completes normally.

Source files
------------

// File: rtl/lsu_mem_master.sv
// Load/store unit: one byte/half/word access per handshake, driving a word-addressed
// memory port with single-cycle strobes and returning extended load data or store status.
module lsu_mem_master #(
    parameter logic MISALIGN_TRAP = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_wfinish
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        wen_q, wen_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;
    logic        unsigned_q, unsigned_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        mem_ren_q, mem_ren_d;
    logic        mem_wen_q, mem_wen_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        req_err_s;

    function automatic logic [3:0] lane_strb(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] strb;
        case (size)
            2'd0:    strb = 4'b0001 << off;
            2'd1:    strb = 4'b0011 << {off[1], 1'b0};
            2'd2:    strb = 4'b1111;
            default: strb = 4'b0000;
        endcase
        return strb;
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] wd;
        case (size)
            2'd0:    wd = {4{data[7:0]}};
            2'd1:    wd = {2{data[15:0]}};
            2'd2:    wd = data;
            default: wd = 32'h0000_0000;
        endcase
        return wd;
    endfunction

    function automatic logic [31:0] load_extend(input logic [1:0] size, input logic [1:0] off,
                                                input logic uns, input logic [31:0] data);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = data[{off, 3'b000} +: 8];
        h = data[{off[1], 4'b0000} +: 16];
        case (size)
            2'd0:    r = {{24{b[7] & ~uns}}, b};
            2'd1:    r = {{16{h[15] & ~uns}}, h};
            2'd2:    r = data;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic m;
        case (size)
            2'd1:    m = off[0];
            2'd2:    m = (off != 2'b00);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    assign req_err_s = (req_size == 2'd3) ||
                       ((MISALIGN_TRAP == 1'b1) && is_misaligned(req_size, req_addr[1:0]));

    // Next-state and registered-output computation
    always_comb begin
        state_d      = state_q;
        wen_d        = wen_q;
        size_d       = size_q;
        off_d        = off_q;
        unsigned_d   = unsigned_q;
        resp_valid_d = resp_valid_q;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;
        mem_ren_d    = 1'b0;
        mem_wen_d    = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wstrb_d  = mem_wstrb_q;
        mem_wdata_d  = mem_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    wen_d      = req_wen;
                    size_d     = req_size;
                    off_d      = req_addr[1:0];
                    unsigned_d = req_unsigned;
                    if (req_err_s) begin
                        // Rejected requests never touch memory
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'h0000_0000;
                    end else begin
                        state_d     = ST_ISSUE;
                        mem_ren_d   = ~req_wen;
                        mem_wen_d   = req_wen;
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                        mem_wstrb_d = req_wen ? lane_strb(req_size, req_addr[1:0]) : 4'b0000;
                        mem_wdata_d = req_wen ? lane_wdata(req_size, req_wdata) : 32'h0000_0000;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
                if (wen_q) begin
                    resp_err_d   = ~mem_wfinish;
                    resp_rdata_d = 32'h0000_0000;
                end else begin
                    resp_err_d   = 1'b0;
                    resp_rdata_d = load_extend(size_q, off_q, unsigned_q, mem_rdata);
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            wen_q        <= 1'b0;
            size_q       <= 2'd0;
            off_q        <= 2'd0;
            unsigned_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0000_0000;
            mem_ren_q    <= 1'b0;
            mem_wen_q    <= 1'b0;
            mem_addr_q   <= 32'h0000_0000;
            mem_wstrb_q  <= 4'b0000;
            mem_wdata_q  <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            wen_q        <= wen_d;
            size_q       <= size_d;
            off_q        <= off_d;
            unsigned_q   <= unsigned_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            mem_ren_q    <= mem_ren_d;
            mem_wen_q    <= mem_wen_d;
            mem_addr_q   <= mem_addr_d;
            mem_wstrb_q  <= mem_wstrb_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_ren    = mem_ren_q;
    assign mem_wen    = mem_wen_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: two instances (trapping and forced-alignment) share one
// stimulus bus and a 16-word memory; results are checked against a byte-level model.
module tb_lsu_mem_master;
    logic        clock = 1'b0;
    logic        reset, mem_init;
    logic        req_valid_a, req_valid_b, req_wen, req_unsigned, resp_ready, wfin_ctl;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;

    logic        a_req_ready, a_resp_valid, a_resp_err, a_mem_ren, a_mem_wen, a_mem_wfinish;
    logic [31:0] a_resp_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic [3:0]  a_mem_wstrb;
    logic        b_req_ready, b_resp_valid, b_resp_err, b_mem_ren, b_mem_wen, b_mem_wfinish;
    logic [31:0] b_resp_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [3:0]  b_mem_wstrb;

    logic [31:0] mem [16];
    logic [31:0] exp_mem [16];
    logic [31:0] last_rdata;
    int checks = 0;
    int errors = 0;

    int a_ren_cnt = 0, a_wen_cnt = 0, b_ren_cnt = 0, b_wen_cnt = 0, both_cnt = 0;
    logic [31:0] a_cap_addr, a_cap_wdata, b_cap_addr, b_cap_wdata;
    logic [3:0]  a_cap_strb, b_cap_strb;

    always #5 clock = ~clock;

    lsu_mem_master #(.MISALIGN_TRAP(1'b1)) dut_a (
        .clock(clock), .reset(reset), .req_valid(req_valid_a), .req_ready(a_req_ready),
        .req_wen(req_wen), .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata), .resp_valid(a_resp_valid), .resp_ready(resp_ready),
        .resp_rdata(a_resp_rdata), .resp_err(a_resp_err), .mem_ren(a_mem_ren), .mem_wen(a_mem_wen),
        .mem_addr(a_mem_addr), .mem_wstrb(a_mem_wstrb), .mem_wdata(a_mem_wdata),
        .mem_rdata(a_mem_rdata), .mem_wfinish(a_mem_wfinish));

    lsu_mem_master #(.MISALIGN_TRAP(1'b0)) dut_b (
        .clock(clock), .reset(reset), .req_valid(req_valid_b), .req_ready(b_req_ready),
        .req_wen(req_wen), .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata), .resp_valid(b_resp_valid), .resp_ready(resp_ready),
        .resp_rdata(b_resp_rdata), .resp_err(b_resp_err), .mem_ren(b_mem_ren), .mem_wen(b_mem_wen),
        .mem_addr(b_mem_addr), .mem_wstrb(b_mem_wstrb), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .mem_wfinish(b_mem_wfinish));

    function automatic logic [31:0] init_word(input int i);
        return (i == 0) ? 32'h12F4_5678 : (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    // Memory model: registered read data and write status; garbage when not strobed
    always @(posedge clock) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (a_mem_wen && a_mem_wstrb[b]) mem[a_mem_addr[5:2]][8*b +: 8] <= a_mem_wdata[8*b +: 8];
                if (b_mem_wen && b_mem_wstrb[b]) mem[b_mem_addr[5:2]][8*b +: 8] <= b_mem_wdata[8*b +: 8];
            end
        end
        a_mem_rdata   <= a_mem_ren ? mem[a_mem_addr[5:2]] : $urandom;
        b_mem_rdata   <= b_mem_ren ? mem[b_mem_addr[5:2]] : $urandom;
        a_mem_wfinish <= a_mem_wen ? wfin_ctl : 1'($urandom);
        b_mem_wfinish <= b_mem_wen ? wfin_ctl : 1'($urandom);
    end

    // Strobe monitor
    always @(negedge clock) begin
        if (a_mem_ren) a_ren_cnt <= a_ren_cnt + 1;
        if (a_mem_wen) a_wen_cnt <= a_wen_cnt + 1;
        if (b_mem_ren) b_ren_cnt <= b_ren_cnt + 1;
        if (b_mem_wen) b_wen_cnt <= b_wen_cnt + 1;
        if ((a_mem_ren && a_mem_wen) || (b_mem_ren && b_mem_wen)) both_cnt <= both_cnt + 1;
        if (a_mem_ren || a_mem_wen) begin
            a_cap_addr <= a_mem_addr; a_cap_strb <= a_mem_wstrb; a_cap_wdata <= a_mem_wdata;
        end
        if (b_mem_ren || b_mem_wen) begin
            b_cap_addr <= b_mem_addr; b_cap_strb <= b_mem_wstrb; b_cap_wdata <= b_mem_wdata;
        end
    end

    // Reference: byte-level rules on the request, independent of any state machine
    function automatic void model(input bit trap, input bit wen, input logic [31:0] addr,
        input logic [1:0] size, input bit uns, input logic [31:0] wd, input bit wfin,
        input logic [31:0] word, output bit early, output bit err, output logic [31:0] rd,
        output logic [3:0] strb, output logic [31:0] mwd, output logic [31:0] nword);
        int nb, off, eoff;
        longint unsigned raw, mask;
        off = int'(addr % 32'd4);
        nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        early = 1'b0; err = 1'b0; rd = 32'h0; strb = 4'h0; mwd = 32'h0; nword = word;
        if (size == 2'd3 || (trap && (off % nb) != 0)) begin
            early = 1'b1; err = 1'b1;
            return;
        end
        eoff = off - (off % nb);
        strb = 4'(((1 << nb) - 1) << eoff);
        if (nb == 1) mwd = (wd & 32'hFF) * 32'h0101_0101;
        else if (nb == 2) mwd = (wd & 32'hFFFF) * 32'h0001_0001;
        else mwd = wd;
        mask = ((64'd1 << (8 * nb)) - 64'd1) << (8 * eoff);
        if (wen) begin
            err = !wfin;
            nword = 32'((64'(word) & ~mask) | (64'(mwd) & mask));
        end else begin
            raw = (64'(word) & mask) >> (8 * eoff);
            if (!uns && nb < 4 && raw >= (64'd1 << (8 * nb - 1))) raw = raw - (64'd1 << (8 * nb));
            rd = 32'(raw);
        end
    endfunction

    function automatic logic [34:0] obs(input bit use_b);
        return use_b ? {b_req_ready, b_resp_valid, b_resp_err, b_resp_rdata}
                     : {a_req_ready, a_resp_valid, a_resp_err, a_resp_rdata};
    endfunction

    task automatic do_txn(input bit use_b, input bit wen, input logic [31:0] addr,
                          input logic [1:0] size, input bit uns, input logic [31:0] wd,
                          input bit wfin, input int hold);
        bit early, err_e;
        logic [31:0] rd_e, mwd_e, word_e, cap_a, cap_d;
        logic [3:0] strb_e, cap_s;
        logic [34:0] o, o0;
        int idx, ren0, wen0, both0, cyc, dr, dw;
        idx = int'(addr[5:2]);
        model(!use_b, wen, addr, size, uns, wd, wfin, exp_mem[idx], early, err_e, rd_e, strb_e, mwd_e, word_e);
        ren0 = use_b ? b_ren_cnt : a_ren_cnt;
        wen0 = use_b ? b_wen_cnt : a_wen_cnt;
        both0 = both_cnt;
        wfin_ctl = wfin; req_wen = wen; req_addr = addr; req_size = size;
        req_unsigned = uns; req_wdata = wd;
        if (use_b) req_valid_b = 1'b1; else req_valid_a = 1'b1;
        o = obs(use_b);
        checks++; if (o[34] !== 1'b1) begin errors++; $display("FAIL txn_ready: got %b want 1", o[34]); end
        @(posedge clock); #1;
        req_valid_a = 1'b0; req_valid_b = 1'b0; cyc = 1;
        o = obs(use_b);
        while (o[33] !== 1'b1 && cyc < 20) begin
            @(posedge clock); #1; cyc++; o = obs(use_b);
        end
        checks++; if (cyc != (early ? 1 : 3)) begin errors++; $display("FAIL latency: got %0d want %0d (addr %h size %0d)", cyc, early ? 1 : 3, addr, size); end
        checks++; if (o[32] !== err_e) begin errors++; $display("FAIL resp_err: got %b want %b (addr %h size %0d wen %b)", o[32], err_e, addr, size, wen); end
        checks++; if (o[31:0] !== rd_e) begin errors++; $display("FAIL resp_rdata: got %h want %h (addr %h size %0d uns %b)", o[31:0], rd_e, addr, size, uns); end
        checks++; if (o[34] !== 1'b0) begin errors++; $display("FAIL ready_in_resp: got %b want 0", o[34]); end
        last_rdata = o[31:0];
        o0 = o;
        for (int k = 0; k < hold; k++) begin
            @(posedge clock); #1; o = obs(use_b);
            checks++; if (o !== o0) begin errors++; $display("FAIL backpressure_hold: got %h want %h", o, o0); end
        end
        dr = (use_b ? b_ren_cnt : a_ren_cnt) - ren0;
        dw = (use_b ? b_wen_cnt : a_wen_cnt) - wen0;
        checks++; if (dr != ((!early && !wen) ? 1 : 0)) begin errors++; $display("FAIL ren_pulses: got %0d want %0d", dr, (!early && !wen) ? 1 : 0); end
        checks++; if (dw != ((!early && wen) ? 1 : 0)) begin errors++; $display("FAIL wen_pulses: got %0d want %0d", dw, (!early && wen) ? 1 : 0); end
        checks++; if (both_cnt != both0) begin errors++; $display("FAIL both_strobes: got %0d want %0d", both_cnt, both0); end
        cap_a = use_b ? b_cap_addr : a_cap_addr;
        cap_s = use_b ? b_cap_strb : a_cap_strb;
        cap_d = use_b ? b_cap_wdata : a_cap_wdata;
        if (!early) begin
            checks++; if (cap_a !== (addr & 32'hFFFF_FFFC)) begin errors++; $display("FAIL mem_addr: got %h want %h", cap_a, addr & 32'hFFFF_FFFC); end
            if (wen) begin
                checks++; if (cap_s !== strb_e) begin errors++; $display("FAIL mem_wstrb: got %b want %b", cap_s, strb_e); end
                checks++; if (cap_d !== mwd_e) begin errors++; $display("FAIL mem_wdata: got %h want %h", cap_d, mwd_e); end
            end
        end
        resp_ready = 1'b1;
        @(posedge clock); #1;
        resp_ready = 1'b0;
        o = obs(use_b);
        checks++; if (o[34:33] !== 2'b10) begin errors++; $display("FAIL release: ready/valid got %b want 10", o[34:33]); end
        if (!early && wen) exp_mem[idx] = word_e;
        checks++; if (mem[idx] !== exp_mem[idx]) begin errors++; $display("FAIL mem_content[%0d]: got %h want %h", idx, mem[idx], exp_mem[idx]); end
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_init = 1'b1; req_valid_a = 1'b0; req_valid_b = 1'b0; resp_ready = 1'b0;
        req_wen = 1'b0; req_addr = 32'h0; req_size = 2'd0; req_unsigned = 1'b0; req_wdata = 32'h0;
        wfin_ctl = 1'b1;
        for (int i = 0; i < 16; i++) exp_mem[i] = init_word(i);
        repeat (3) @(posedge clock);
        #1;
        checks++; if ({a_req_ready, a_resp_valid, a_resp_err, a_mem_ren, a_mem_wen} !== 5'b10000) begin
            errors++; $display("FAIL reset_ctrl_a: got %b want 10000", {a_req_ready, a_resp_valid, a_resp_err, a_mem_ren, a_mem_wen}); end
        checks++; if ({a_resp_rdata, a_mem_addr, a_mem_wstrb, a_mem_wdata} !== 100'h0) begin
            errors++; $display("FAIL reset_data_a: got %h want 0", {a_resp_rdata, a_mem_addr, a_mem_wstrb, a_mem_wdata}); end
        checks++; if ({b_req_ready, b_resp_valid, b_mem_ren, b_mem_wen} !== 4'b1000) begin
            errors++; $display("FAIL reset_ctrl_b: got %b want 1000", {b_req_ready, b_resp_valid, b_mem_ren, b_mem_wen}); end
        reset = 1'b0; mem_init = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_load_byte();
        do_txn(1'b0, 1'b0, 32'h8000_0002, 2'd0, 1'b0, 32'h0, 1'b1, 0);
        checks++; if (last_rdata !== 32'hFFFF_FFF4) begin errors++; $display("FAIL lb_signed: got %h want fffffff4", last_rdata); end
        do_txn(1'b0, 1'b0, 32'h8000_0002, 2'd0, 1'b1, 32'h0, 1'b1, 0);
        checks++; if (last_rdata !== 32'h0000_00F4) begin errors++; $display("FAIL lbu: got %h want 000000f4", last_rdata); end
    endtask

    task automatic test_store_half();
        do_txn(1'b0, 1'b1, 32'h8000_0006, 2'd1, 1'b0, 32'hDEAD_BEEF, 1'b1, 0);
        checks++; if ({a_cap_addr, a_cap_strb, a_cap_wdata} !== {32'h8000_0004, 4'b1100, 32'hBEEF_BEEF}) begin
            errors++; $display("FAIL sh_lanes: got %h/%b/%h want 80000004/1100/beefbeef", a_cap_addr, a_cap_strb, a_cap_wdata); end
    endtask

    task automatic test_misaligned();
        do_txn(1'b0, 1'b0, 32'h8000_0001, 2'd2, 1'b0, 32'h0, 1'b1, 0);
        do_txn(1'b1, 1'b0, 32'h8000_0001, 2'd2, 1'b0, 32'h0, 1'b1, 0);
        checks++; if (last_rdata !== 32'h12F4_5678) begin errors++; $display("FAIL forced_align_word: got %h want 12f45678", last_rdata); end
    endtask

    task automatic test_errors();
        do_txn(1'b0, 1'b1, 32'h8000_0008, 2'd2, 1'b0, 32'hCAFE_F00D, 1'b0, 0);
        do_txn(1'b0, 1'b0, 32'h8000_000C, 2'd3, 1'b0, 32'h0, 1'b1, 0);
        do_txn(1'b1, 1'b1, 32'h8000_000C, 2'd3, 1'b0, 32'h1234_5678, 1'b1, 0);
    endtask

    task automatic test_backpressure();
        do_txn(1'b0, 1'b0, 32'h8000_0000, 2'd1, 1'b0, 32'h0, 1'b1, 5);
        do_txn(1'b1, 1'b1, 32'h8000_0011, 2'd0, 1'b0, 32'h0000_00A5, 1'b1, 5);
    endtask

    task automatic set_rand_load(output logic [31:0] exp_v);
        bit early, err_e;
        logic [31:0] mwd_e, word_e;
        logic [3:0] strb_e;
        logic [1:0] sz;
        logic [31:0] ad;
        sz = 2'($urandom_range(0, 2));
        ad = 32'h8000_0000 | (32'($urandom_range(0, 15)) << 2);
        if (sz == 2'd0) ad = ad | 32'($urandom_range(0, 3));
        else if (sz == 2'd1) ad = ad | (32'($urandom_range(0, 1)) << 1);
        else ad = ad;
        req_wen = 1'b0; req_addr = ad; req_size = sz; req_unsigned = 1'($urandom);
        req_wdata = $urandom;
        model(1'b1, 1'b0, ad, sz, req_unsigned, req_wdata, 1'b1, exp_mem[ad[5:2]],
              early, err_e, exp_v, strb_e, mwd_e, word_e);
    endtask

    task automatic test_back_to_back();
        logic [31:0] q[$];
        logic [31:0] exp_v;
        int pushes, got, cyc, last, ren0;
        pushes = 0; got = 0; cyc = 0; last = -1; ren0 = a_ren_cnt;
        resp_ready = 1'b1;
        set_rand_load(exp_v); q.push_back(exp_v); pushes++;
        req_valid_a = 1'b1;
        while (got < 6 && cyc < 100) begin
            @(posedge clock); #1; cyc++;
            if (a_resp_valid === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL b2b_extra_resp: got %h want none", a_resp_rdata);
                end else begin
                    exp_v = q.pop_front();
                    if (a_resp_rdata !== exp_v) begin errors++; $display("FAIL b2b_rdata: got %h want %h", a_resp_rdata, exp_v); end
                end
                if (last >= 0) begin
                    checks++; if (cyc - last != 4) begin errors++; $display("FAIL b2b_period: got %0d want 4", cyc - last); end
                end
                last = cyc; got++;
            end
            if (a_req_ready === 1'b1) begin
                if (pushes < 6) begin set_rand_load(exp_v); q.push_back(exp_v); pushes++; end
                else req_valid_a = 1'b0;
            end
        end
        req_valid_a = 1'b0;
        @(posedge clock); #1;
        resp_ready = 1'b0;
        checks++; if (got != 6) begin errors++; $display("FAIL b2b_count: got %0d want 6", got); end
        checks++; if (a_ren_cnt - ren0 != 6) begin errors++; $display("FAIL b2b_ren: got %0d want 6", a_ren_cnt - ren0); end
    endtask

    task automatic test_reset_midop();
        bit seen;
        req_wen = 1'b0; req_addr = 32'h8000_0014; req_size = 2'd2; req_unsigned = 1'b0;
        req_valid_a = 1'b1;
        @(posedge clock); #1;
        req_valid_a = 1'b0;
        checks++; if (a_mem_ren !== 1'b1) begin errors++; $display("FAIL midop_issue: got %b want 1", a_mem_ren); end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        checks++; if ({a_mem_ren, a_resp_valid, a_req_ready, a_mem_addr} !== {3'b001, 32'h0}) begin
            errors++; $display("FAIL midop_reset: got %b%b%b %h want 001 0", a_mem_ren, a_resp_valid, a_req_ready, a_mem_addr); end
        seen = 1'b0;
        repeat (4) begin @(posedge clock); #1; if (a_resp_valid !== 1'b0 || a_mem_ren !== 1'b0) seen = 1'b1; end
        checks++; if (seen) begin errors++; $display("FAIL midop_quiet: got activity want none"); end
        do_txn(1'b0, 1'b0, 32'h8000_0014, 2'd2, 1'b0, 32'h0, 1'b1, 0);
    endtask

    task automatic test_random();
        logic [1:0] sz;
        for (int i = 0; i < 40; i++) begin
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            do_txn(1'($urandom), 1'($urandom),
                   32'h8000_0000 | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3)),
                   sz, 1'($urandom), $urandom, ($urandom_range(0, 3) != 0), int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        test_reset();
        test_load_byte();
        test_store_half();
        test_misaligned();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
